dram_arbiter: RTL and testbench

Two-port arbiter sharing the single DRAM controller's user port between two requesters. It sits between the DRAM block and its clients: port 0 is the loader/DMA side and port 1 is the processor data-memory side. Each port has a one-entry pending register. Port selection is round-robin. At most one read is outstanding, and read data is steered back to the port that issued the read.

---
 rtl/dram_arbiter.sv | 178 +++++++++++++++++
 tb/tb_dram_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_arbiter.sv
// dram_arbiter: shares the single DRAM controller user port between two
// requesters (port 0 = loader/DMA, port 1 = processor data memory).
// Each port owns a one-entry pending slot; slots are issued round-robin,
// at most one read is in flight, and read data is steered to its issuer.
// Build option: define DRAM_ARB_FIXED_PRIO_EN to make port 0 always win a
// tie (port 1 may then starve, which is tolerable during loader-only phases).
module dram_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int BW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_oe,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  input  logic [BW-1:0] p0_we,
  output logic          p0_ready,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_valid,
  input  logic          p1_oe,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  input  logic [BW-1:0] p1_we,
  output logic          p1_ready,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_valid,
  output logic          dram_oe,
  output logic [AW-1:0] dram_addr,
  output logic [DW-1:0] dram_wdata,
  output logic [BW-1:0] dram_we,
  input  logic [DW-1:0] dram_rdata,
  input  logic          dram_valid,
  input  logic          dram_busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GAP     = 2'd1,
    ST_WAIT_RD = 2'd2
  } state_t;

  state_t        state_reg;
  logic          owner_reg;
`ifndef DRAM_ARB_FIXED_PRIO_EN
  logic          last_reg;
`endif

  // Per-port request inputs gathered into arrays so the slots can be generated.
  logic [1:0]    req_oe;
  logic [AW-1:0] req_addr  [2];
  logic [DW-1:0] req_wdata [2];
  logic [BW-1:0] req_we    [2];

  // Pending slot contents, one entry per port.
  logic [1:0]    pend_vec;
  logic [AW-1:0] pend_addr  [2];
  logic [DW-1:0] pend_wdata [2];
  logic [BW-1:0] pend_we    [2];

  logic          issue_now;
  logic          grant;
  logic [1:0]    issue_clr;

  assign req_oe       = {p1_oe, p0_oe};
  assign req_addr[0]  = p0_addr;
  assign req_addr[1]  = p1_addr;
  assign req_wdata[0] = p0_wdata;
  assign req_wdata[1] = p1_wdata;
  assign req_we[0]    = p0_we;
  assign req_we[1]    = p1_we;

  // An issue only ever happens from IDLE with something pending and DRAM free.
  assign issue_now    = (state_reg == ST_IDLE) && (|pend_vec) && !dram_busy;
  assign issue_clr[0] = issue_now && !grant;
  assign issue_clr[1] = issue_now &&  grant;

  // Arbitration: a lone pending port wins; a tie goes to the non-last port
  // (or always to port 0 in the fixed-priority build).
  always_comb begin
    grant = 1'b0;
`ifdef DRAM_ARB_FIXED_PRIO_EN
    grant = !pend_vec[0];
`else
    if (pend_vec[0] && pend_vec[1]) begin
      grant = !last_reg;
    end else begin
      grant = pend_vec[1];
    end
`endif
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_pend
      logic          pend_reg;
      logic [AW-1:0] addr_reg;
      logic [DW-1:0] wdata_reg;
      logic [BW-1:0] we_reg;

      // Pending slot: load on an accepted strobe, clear when this port is issued.
      // Accept and issue cannot coincide on one port: accept needs an empty slot.
      always_ff @(posedge clk) begin
        if (rst) begin
          pend_reg  <= 1'b0;
          addr_reg  <= '0;
          wdata_reg <= '0;
          we_reg    <= '0;
        end else if (req_oe[gi] && !pend_reg) begin
          pend_reg  <= 1'b1;
          addr_reg  <= req_addr[gi];
          wdata_reg <= req_wdata[gi];
          we_reg    <= req_we[gi];
        end else if (issue_clr[gi]) begin
          pend_reg  <= 1'b0;
        end
      end

      assign pend_vec[gi]   = pend_reg;
      assign pend_addr[gi]  = addr_reg;
      assign pend_wdata[gi] = wdata_reg;
      assign pend_we[gi]    = we_reg;
    end
  endgenerate

  // Issue FSM with registered DRAM command outputs; GAP gives dram_busy one
  // cycle to reflect a write, WAIT_RD holds off everything until read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      owner_reg  <= 1'b0;
`ifndef DRAM_ARB_FIXED_PRIO_EN
      last_reg   <= 1'b1;
`endif
      dram_oe    <= 1'b0;
      dram_addr  <= '0;
      dram_wdata <= '0;
      dram_we    <= '0;
    end else begin
      dram_oe <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (issue_now) begin
            dram_oe    <= 1'b1;
            dram_addr  <= pend_addr[grant];
            dram_wdata <= pend_wdata[grant];
            dram_we    <= pend_we[grant];
            owner_reg  <= grant;
`ifndef DRAM_ARB_FIXED_PRIO_EN
            last_reg   <= grant;
`endif
            state_reg  <= (pend_we[grant] == '0) ? ST_WAIT_RD : ST_GAP;
          end
        end
        ST_GAP: begin
          state_reg <= ST_IDLE;
        end
        ST_WAIT_RD: begin
          if (dram_valid) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign p0_ready = !pend_vec[0];
  assign p1_ready = !pend_vec[1];

  // Read return is steered combinationally; stray dram_valid outside WAIT_RD is dropped.
  assign p0_valid = dram_valid && (state_reg == ST_WAIT_RD) && !owner_reg;
  assign p1_valid = dram_valid && (state_reg == ST_WAIT_RD) &&  owner_reg;
  assign p0_rdata = dram_rdata;
  assign p1_rdata = dram_rdata;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: expected DRAM commands and read returns are queued
// when stimulus is driven and popped by a monitor when the DUT produces them;
// scenario tasks additionally check timing and handshake levels inline.
module tb_dram_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_oe, p1_oe;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic [BW-1:0] p0_we, p1_we;
  logic          p0_ready, p1_ready;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          p0_valid, p1_valid;
  logic          dram_oe;
  logic [AW-1:0] dram_addr;
  logic [DW-1:0] dram_wdata;
  logic [BW-1:0] dram_we;
  logic [DW-1:0] dram_rdata;
  logic          dram_valid;
  logic          dram_busy;

  dram_arbiter #(.AW(AW), .DW(DW), .BW(BW)) dut (
    .clk(clk), .rst(rst),
    .p0_oe(p0_oe), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_we(p0_we),
    .p0_ready(p0_ready), .p0_rdata(p0_rdata), .p0_valid(p0_valid),
    .p1_oe(p1_oe), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_we(p1_we),
    .p1_ready(p1_ready), .p1_rdata(p1_rdata), .p1_valid(p1_valid),
    .dram_oe(dram_oe), .dram_addr(dram_addr), .dram_wdata(dram_wdata),
    .dram_we(dram_we), .dram_rdata(dram_rdata), .dram_valid(dram_valid),
    .dram_busy(dram_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] we;
  } iss_t;

  typedef struct packed {
    logic          port;
    logic [DW-1:0] data;
  } rsp_t;

  iss_t iss_q[$];
  rsp_t rsp_q[$];
  iss_t mon_iss;
  rsp_t mon_rsp;
  int   errors = 0;
  int   checks = 0;

  // Scoreboard monitor: every DRAM issue and every port read return must match
  // the head of its expectation queue; anything unexpected is a failure.
  always @(negedge clk) begin
    if (dram_oe === 1'b1) begin
      checks++;
      if (iss_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got addr=%h we=%h, required no issue", dram_addr, dram_we);
      end else begin
        mon_iss = iss_q.pop_front();
        if ({dram_addr, dram_wdata, dram_we} !== mon_iss) begin
          errors++;
          $display("FAIL issue_content: got addr=%h wdata=%h we=%h, required addr=%h wdata=%h we=%h",
                   dram_addr, dram_wdata, dram_we, mon_iss.addr, mon_iss.wdata, mon_iss.we);
        end else begin
          $display("issue addr=%h wdata=%h we=%h", dram_addr, dram_wdata, dram_we);
        end
      end
    end
    if (p0_valid === 1'b1 || p1_valid === 1'b1) begin
      checks++;
      if (rsp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got p0_valid=%b p1_valid=%b, required none", p0_valid, p1_valid);
      end else begin
        mon_rsp = rsp_q.pop_front();
        if ((p0_valid === 1'b1 && p1_valid === 1'b1) ||
            (p1_valid !== mon_rsp.port) ||
            ((mon_rsp.port ? p1_rdata : p0_rdata) !== mon_rsp.data)) begin
          errors++;
          $display("FAIL rsp_content: got p0_valid=%b p1_valid=%b rdata=%h, required port=%0d rdata=%h",
                   p0_valid, p1_valid, mon_rsp.port ? p1_rdata : p0_rdata, mon_rsp.port, mon_rsp.data);
        end else begin
          $display("response port=%0d rdata=%h", mon_rsp.port, mon_rsp.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    p0_oe = 1'b0; p0_addr = '0; p0_wdata = '0; p0_we = '0;
    p1_oe = 1'b0; p1_addr = '0; p1_wdata = '0; p1_we = '0;
    dram_rdata = '0; dram_valid = 1'b0; dram_busy = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({p0_ready, p1_ready} !== 2'b11) begin
      errors++; $display("FAIL reset_ready: got %b, required 11", {p0_ready, p1_ready});
    end
    checks++;
    if ({p0_valid, p1_valid} !== 2'b00) begin
      errors++; $display("FAIL reset_valid: got %b, required 00", {p0_valid, p1_valid});
    end
    checks++;
    if (dram_oe !== 1'b0) begin
      errors++; $display("FAIL reset_dram_oe: got %b, required 0", dram_oe);
    end
    checks++;
    if ({dram_addr, dram_wdata, dram_we} !== '0) begin
      errors++; $display("FAIL reset_dram_cmd: got addr=%h wdata=%h we=%h, required all 0",
                         dram_addr, dram_wdata, dram_we);
    end
    $display("reset done");
  endtask

  task automatic test_single_read();
    iss_q.push_back('{addr: 32'h100, wdata: 32'h0, we: 4'h0});
    rsp_q.push_back('{port: 1'b1, data: 32'hCAFEBABE});
    p1_oe = 1'b1; p1_addr = 32'h100; p1_wdata = 32'h0; p1_we = 4'h0;
    tick();                                   // E0: accepted
    p1_oe = 1'b0;
    checks++;
    if (p1_ready !== 1'b0 || dram_oe !== 1'b0) begin
      errors++; $display("FAIL read_accept: got ready=%b oe=%b, required ready=0 oe=0", p1_ready, dram_oe);
    end
    tick();                                   // E1: issued
    checks++;
    if (dram_oe !== 1'b1 || dram_addr !== 32'h100 || dram_we !== 4'h0) begin
      errors++; $display("FAIL read_issue: got oe=%b addr=%h we=%h, required oe=1 addr=100 we=0",
                         dram_oe, dram_addr, dram_we);
    end
    checks++;
    if (p1_ready !== 1'b1) begin
      errors++; $display("FAIL read_ready_back: got %b, required 1", p1_ready);
    end
    tick();
    checks++;
    if (dram_oe !== 1'b0) begin
      errors++; $display("FAIL read_oe_pulse: got %b, required 0", dram_oe);
    end
    for (int i = 0; i < 4; i++) tick();       // DRAM answers 5 cycles after dram_oe
    dram_valid = 1'b1; dram_rdata = 32'hCAFEBABE;
    #1;
    checks++;
    if (p1_valid !== 1'b1 || p1_rdata !== 32'hCAFEBABE || p0_valid !== 1'b0) begin
      errors++; $display("FAIL read_return: got p1_valid=%b p1_rdata=%h p0_valid=%b, required 1 cafebabe 0",
                         p1_valid, p1_rdata, p0_valid);
    end
    tick();
    dram_valid = 1'b0; dram_rdata = 32'h0;
    #1;
    checks++;
    if (p1_valid !== 1'b0) begin
      errors++; $display("FAIL read_valid_pulse: got %b, required 0", p1_valid);
    end
    tick();
  endtask

  task automatic test_tie();
    logic [AW-1:0] order [3];
    rst = 1'b1; tick(); rst = 1'b0;
    // Second tie forms at the third edge: p1 still pending, p0 re-requested.
`ifdef DRAM_ARB_FIXED_PRIO_EN
    order[0] = 32'h0; order[1] = 32'h8; order[2] = 32'h4;
`else
    order[0] = 32'h0; order[1] = 32'h4; order[2] = 32'h8;
`endif
    for (int i = 0; i < 3; i++)
      iss_q.push_back('{addr: order[i], wdata: 32'hA5A50000 | order[i], we: 4'hF});
    p0_oe = 1'b1; p0_addr = 32'h0; p0_wdata = 32'hA5A50000; p0_we = 4'hF;
    p1_oe = 1'b1; p1_addr = 32'h4; p1_wdata = 32'hA5A50004; p1_we = 4'hF;
    tick();                                   // E0: both accepted
    p0_oe = 1'b0; p1_oe = 1'b0;
    tick();                                   // E1: first issue
    checks++;
    if (dram_oe !== 1'b1 || dram_addr !== order[0]) begin
      errors++; $display("FAIL tie_first: got oe=%b addr=%h, required oe=1 addr=%h", dram_oe, dram_addr, order[0]);
    end
    checks++;
    if (p0_ready !== 1'b1 || p1_ready !== 1'b0) begin
      errors++; $display("FAIL tie_ready: got p0=%b p1=%b, required p0=1 p1=0", p0_ready, p1_ready);
    end
    p0_oe = 1'b1; p0_addr = 32'h8; p0_wdata = 32'hA5A50008; p0_we = 4'hF;
    tick();                                   // E2: gap, p0 re-accepted
    p0_oe = 1'b0;
    checks++;
    if (dram_oe !== 1'b0) begin
      errors++; $display("FAIL tie_gap1: got oe=%b, required 0", dram_oe);
    end
    tick();                                   // E3: second issue (2 edges after first)
    checks++;
    if (dram_oe !== 1'b1 || dram_addr !== order[1]) begin
      errors++; $display("FAIL tie_second: got oe=%b addr=%h, required oe=1 addr=%h", dram_oe, dram_addr, order[1]);
    end
    tick();
    checks++;
    if (dram_oe !== 1'b0) begin
      errors++; $display("FAIL tie_gap2: got oe=%b, required 0", dram_oe);
    end
    tick();                                   // E5: third issue
    checks++;
    if (dram_oe !== 1'b1 || dram_addr !== order[2]) begin
      errors++; $display("FAIL tie_third: got oe=%b addr=%h, required oe=1 addr=%h", dram_oe, dram_addr, order[2]);
    end
    tick(); tick();
  endtask

  task automatic test_busy_stall();
    iss_q.push_back('{addr: 32'h200, wdata: 32'h11112222, we: 4'h3});
    dram_busy = 1'b1;
    p0_oe = 1'b1; p0_addr = 32'h200; p0_wdata = 32'h11112222; p0_we = 4'h3;
    tick();
    p0_oe = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        p0_oe = 1'b1; p0_addr = 32'h300; p0_wdata = 32'h33334444; p0_we = 4'hF;
      end else begin
        p0_oe = 1'b0;
      end
      tick();
      checks++;
      if (dram_oe !== 1'b0 || p0_ready !== 1'b0) begin
        errors++; $display("FAIL busy_hold cycle %0d: got oe=%b ready=%b, required oe=0 ready=0", i, dram_oe, p0_ready);
      end
    end
    p0_oe = 1'b0;
    dram_busy = 1'b0;
    tick();
    checks++;
    if (dram_oe !== 1'b1 || dram_addr !== 32'h200 || dram_wdata !== 32'h11112222) begin
      errors++; $display("FAIL busy_release: got oe=%b addr=%h wdata=%h, required oe=1 addr=200 wdata=11112222",
                         dram_oe, dram_addr, dram_wdata);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dram_oe !== 1'b0 || p0_ready !== 1'b1) begin
        errors++; $display("FAIL busy_ignored cycle %0d: got oe=%b ready=%b, required oe=0 ready=1", i, dram_oe, p0_ready);
      end
    end
  endtask

  task automatic test_read_blocking();
    iss_q.push_back('{addr: 32'h400, wdata: 32'h0, we: 4'h0});
    iss_q.push_back('{addr: 32'h500, wdata: 32'hDEAD0500, we: 4'hC});
    rsp_q.push_back('{port: 1'b0, data: 32'h12345678});
    p0_oe = 1'b1; p0_addr = 32'h400; p0_wdata = 32'h0; p0_we = 4'h0;
    tick();
    p0_oe = 1'b0;
    tick();                                   // read issued
    checks++;
    if (dram_oe !== 1'b1 || dram_addr !== 32'h400) begin
      errors++; $display("FAIL block_read_issue: got oe=%b addr=%h, required oe=1 addr=400", dram_oe, dram_addr);
    end
    p1_oe = 1'b1; p1_addr = 32'h500; p1_wdata = 32'hDEAD0500; p1_we = 4'hC;
    tick();
    p1_oe = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (dram_oe !== 1'b0) begin
        errors++; $display("FAIL block_hold cycle %0d: got oe=%b, required 0", i, dram_oe);
      end
    end
    dram_valid = 1'b1; dram_rdata = 32'h12345678;
    #1;
    checks++;
    if (p0_valid !== 1'b1 || p1_valid !== 1'b0 || p0_rdata !== 32'h12345678) begin
      errors++; $display("FAIL block_return: got p0_valid=%b p1_valid=%b rdata=%h, required 1 0 12345678",
                         p0_valid, p1_valid, p0_rdata);
    end
    tick();                                   // edge with dram_valid
    dram_valid = 1'b0; dram_rdata = 32'h0;
    checks++;
    if (dram_oe !== 1'b0) begin
      errors++; $display("FAIL block_early: got oe=%b, required 0", dram_oe);
    end
    tick();                                   // edge after dram_valid
    checks++;
    if (dram_oe !== 1'b1 || dram_addr !== 32'h500 || dram_we !== 4'hC) begin
      errors++; $display("FAIL block_write_issue: got oe=%b addr=%h we=%h, required oe=1 addr=500 we=c",
                         dram_oe, dram_addr, dram_we);
    end
    tick(); tick();
  endtask

  task automatic test_reset_mid_read();
    iss_q.push_back('{addr: 32'h600, wdata: 32'h0, we: 4'h0});
    p1_oe = 1'b1; p1_addr = 32'h600; p1_wdata = 32'h0; p1_we = 4'h0;
    tick();
    p1_oe = 1'b0;
    tick();                                   // read issued, now WAIT_RD
    p0_oe = 1'b1; p0_addr = 32'h700; p0_wdata = 32'h77777777; p0_we = 4'hF;
    tick();                                   // p0 pending behind the read
    p0_oe = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dram_valid = 1'b1; dram_rdata = 32'hBAD0BAD0;
    #1;
    checks++;
    if ({p0_valid, p1_valid} !== 2'b00) begin
      errors++; $display("FAIL rst_rd_valid: got %b, required 00", {p0_valid, p1_valid});
    end
    checks++;
    if ({p0_ready, p1_ready} !== 2'b11 || dram_oe !== 1'b0) begin
      errors++; $display("FAIL rst_rd_state: got ready=%b oe=%b, required ready=11 oe=0", {p0_ready, p1_ready}, dram_oe);
    end
    tick();
    dram_valid = 1'b0; dram_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dram_oe !== 1'b0) begin
        errors++; $display("FAIL rst_rd_dropped cycle %0d: got oe=%b, required 0", i, dram_oe);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_busy_stall();
    test_read_blocking();
    test_reset_mid_read();
    checks++;
    if (iss_q.size() != 0) begin
      errors++; $display("FAIL issue_leftover: got %0d outstanding, required 0", iss_q.size());
    end
    checks++;
    if (rsp_q.size() != 0) begin
      errors++; $display("FAIL rsp_leftover: got %0d outstanding, required 0", rsp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
